// File: rtl/weightmemory_banked_wrapper.sv
// Banked weight memory with a single-slot read retry buffer.
// Words are interleaved across NUM_BANKS single-port banks on the low address
// bits. Writes always win their bank; a read landing on the bank being written
// parks in one pending slot and retries every cycle until that bank is free.
//
// Handshake: a read is accepted on a cycle where read_enable_i && read_ready_o;
// read_ready_o depends on registered state only, and no accepted read is ever
// dropped except by reset. Each issued read yields exactly one rdata_valid_o
// pulse one cycle later, in acceptance order.
module weightmemory_banked_wrapper #(
  parameter  int DATA_WIDTH = 520,
  parameter  int NUM_BANKS  = 4,
  parameter  int BANKDEPTH  = 256,
  parameter  int CNT_WIDTH  = 16,
  localparam int AW         = $clog2(NUM_BANKS * BANKDEPTH),
  localparam int BW         = $clog2(NUM_BANKS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_enable_i,
  input  logic [AW-1:0]         write_addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  read_enable_i,
  input  logic [AW-1:0]         read_addr_i,
  output logic                  read_ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  rw_collision_o,
  output logic [CNT_WIDTH-1:0]  collision_count_o
);

  localparam int RW = AW - BW;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Storage: one array per bank, contents deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][BANKDEPTH];

  logic                  pending_valid_q, pending_valid_d;
  logic [AW-1:0]         pending_addr_q,  pending_addr_d;
  logic                  rdata_valid_q,   rdata_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q,         rdata_d;
  logic [CNT_WIDTH-1:0]  count_q,         count_d;

  logic          wr_en;
  logic [BW-1:0] wr_bank;
  logic [RW-1:0] wr_row;
  logic          accept;
  logic          cand_valid;
  logic [AW-1:0] cand_addr;
  logic [BW-1:0] cand_bank;
  logic [RW-1:0] cand_row;
  logic          blocked;
  logic          issue;

  // Arbitration: pick the read candidate (pending slot first) and decide
  // whether it issues or waits behind a same-bank write.
  always_comb begin
    wr_en      = write_enable_i & ~rst_i;
    wr_bank    = write_addr_i[BW-1:0];
    wr_row     = write_addr_i[AW-1:BW];
    accept     = read_enable_i & ~pending_valid_q;
    cand_valid = (pending_valid_q | accept) & ~rst_i;
    cand_addr  = pending_valid_q ? pending_addr_q : read_addr_i;
    cand_bank  = cand_addr[BW-1:0];
    cand_row   = cand_addr[AW-1:BW];
    blocked    = cand_valid & wr_en & (cand_bank == wr_bank);
    issue      = cand_valid & ~blocked;
  end

  // Next-state: park blocked reads, capture issued data, count blocked cycles.
  always_comb begin
    pending_valid_d = blocked;
    pending_addr_d  = blocked ? cand_addr : pending_addr_q;
    rdata_valid_d   = issue;
    rdata_d         = issue ? mem_q[cand_bank][cand_row] : rdata_q;
    count_d         = (blocked && (count_q != CNT_MAX)) ? count_q + CNT_ONE : count_q;
  end

  // Bank write port; the arbitration guarantees no same-bank read this cycle.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_bank][wr_row] <= wdata_i;
    end
  end

  // Control and read-data registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_valid_q <= 1'b0;
      pending_addr_q  <= '0;
      rdata_valid_q   <= 1'b0;
      rdata_q         <= '0;
      count_q         <= '0;
    end else begin
      pending_valid_q <= pending_valid_d;
      pending_addr_q  <= pending_addr_d;
      rdata_valid_q   <= rdata_valid_d;
      rdata_q         <= rdata_d;
      count_q         <= count_d;
    end
  end

  // Outputs: ready is state-only, collision is the live blocked condition.
  always_comb begin
    read_ready_o      = ~pending_valid_q;
    rdata_o           = rdata_q;
    rdata_valid_o     = rdata_valid_q;
    rw_collision_o    = blocked;
    collision_count_o = count_q;
  end

endmodule

// File: doc/weightmemory_banked_wrapper.md
WEIGHTMEMORY_BANKED_WRAPPER -- requirements
Module: weightmemory_banked_wrapper

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 520, meaning the width of one encoded weight word in bits.
REQ-002 SHALL have parameter NUM_BANKS, default 4, meaning the number of independent single-port banks; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter BANKDEPTH, default 256, meaning the number of words per bank; must be a power of 2.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the collision counter.
REQ-005 SHALL derive local parameter AW = $clog2(NUM_BANKS*BANKDEPTH) and BW = $clog2(NUM_BANKS).
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port write_enable_i, input, 1 bit: write request, always accepted.
REQ-009 SHALL have port write_addr_i, input, AW bits: write word address.
REQ-010 SHALL have port wdata_i, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port read_enable_i, input, 1 bit: read request.
REQ-012 SHALL have port read_addr_i, input, AW bits: read word address.
REQ-013 SHALL have port read_ready_o, output, 1 bit: read request is accepted this cycle if high.
REQ-014 SHALL have port rdata_o, output, DATA_WIDTH bits: read data.
REQ-015 SHALL have port rdata_valid_o, output, 1 bit: rdata_o valid this cycle.
REQ-016 SHALL have port rw_collision_o, output, 1 bit: a read is blocked by a write this cycle.
REQ-017 SHALL have port collision_count_o, output, CNT_WIDTH bits: count of blocked-read cycles.

Function
REQ-018 Bank select SHALL be addr[BW-1:0] and row SHALL be addr[AW-1:BW] (low-order interleaving).
REQ-019 A write SHALL update its bank/row at the clock edge in which write_enable_i is high; writes always take priority.
REQ-020 read_ready_o SHALL equal NOT pending_valid, a registered flag, and SHALL be purely state-derived (no input-to-ready path).
REQ-021 A read is accepted when read_enable_i and read_ready_o are both high.
REQ-022 An accepted read whose bank differs from the bank of a same-cycle write, or with no write, SHALL issue immediately.
REQ-023 An accepted read whose bank equals the bank of a same-cycle write SHALL be stored in the single pending slot (address captured) and not issued.
REQ-024 A pending read SHALL retry every cycle and issue in the first cycle with no write to its bank; pending_valid then clears.
REQ-025 Reads to different banks than the same-cycle write SHALL proceed in parallel with that write.
REQ-026 Read latency SHALL be 1 cycle: rdata_valid_o is high and rdata_o holds the addressed word in the cycle after issue.
REQ-027 A read issued in the cycle after a write to the same address SHALL return the newly written data.
REQ-028 rdata_o SHALL hold its last value while rdata_valid_o is low.
REQ-029 rw_collision_o SHALL be high combinationally in any cycle in which a new or pending read is blocked by a same-bank write.
REQ-030 collision_count_o SHALL increment by 1 in every cycle rw_collision_o is high, saturating at 2^CNT_WIDTH-1 without wrap.
REQ-031 Read responses SHALL be returned in acceptance order; at most one read is outstanding in the pending slot.

Reset
REQ-032 While rst_i is high at a clock edge: pending_valid=0, rdata_valid_o=0, rdata_o=0, collision_count_o=0; hence read_ready_o=1 after reset.
REQ-033 Memory contents SHALL NOT be reset; a write or read presented in a reset cycle SHALL be ignored, and a pending read is discarded.

Verification
REQ-034 Write 0xA5.. to addr 5, then read addr 5 next cycle -> rdata_valid_o=1 one cycle after read, rdata_o=0xA5.., rw_collision_o never high.
REQ-035 Same cycle: write addr 4 (bank 0), read addr 9 (bank 1) -> no collision, read data valid next cycle, read_ready_o stays 1.
REQ-036 Same cycle: write addr 8 (bank 0), read addr 8 -> rw_collision_o=1, read_ready_o=0 next cycle, read issues the next write-free cycle and returns the new data; collision_count_o=1.
REQ-037 Pending read on bank 2 with writes to bank 2 for 3 further cycles -> rw_collision_o high 4 cycles, count=4, single rdata_valid_o pulse afterwards.
REQ-038 CNT_WIDTH=2, 5 blocked cycles -> collision_count_o saturates at 3.
REQ-039 Assert rst_i while a read is pending -> next cycle read_ready_o=1, rdata_valid_o=0, count=0, no response for the discarded read.
